duty_meter: RTL

Measures the period and high time of a slow single-bit clock-like signal, counted in `clk_in` cycles, and flags whether the duty cycle is exactly one third. It is the receiving end for the team's divided and duty-cycle clock generators. On the bench it checks generator outputs. In hardware it feeds status LEDs and the seven-segment display.

---
 rtl/duty_meter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/duty_meter.sv
// duty_meter: measures period and high time of a slow clock-like signal in
// clk_in cycles, flags an exact one-third duty cycle and reports lock when two
// consecutive measurements agree. A counter that reaches its limit without a
// new rising edge raises a one-cycle timeout and returns to IDLE.
// Optional build macro: DUTY_SYNC_EN inserts a two-flop synchronizer ahead of
// the sampling registers for sources that are asynchronous to clk_in.
module duty_meter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             duty_33,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    // Value one below saturation: the counter hits CNT_MAX on the next edge.
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

`ifdef DUTY_SYNC_EN
    // Sync stages plus s_cur and s_prev must all hold real samples.
    localparam int VLD_W = 4;
`else
    localparam int VLD_W = 2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    logic             w_sig_src;
    logic             r_s_cur;
    logic             r_s_prev;
    logic [VLD_W-1:0] r_vld;
    logic             w_rise;
    logic             w_fall;
    logic             w_to;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_high;
    logic             r_have_prev;
    logic [CNT_W+1:0] w_three_high;
    logic             w_duty_hit;
    logic             w_match;
    state_t           r_state;

`ifdef DUTY_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchronizer for an asynchronous sig_in.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sig_src = r_sync2;
`else
    assign w_sig_src = sig_in;
`endif

    // Sample the signal and track when the pipeline holds real (post-reset) data.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_s_cur  <= 1'b0;
            r_s_prev <= 1'b0;
            r_vld    <= '0;
        end else begin
            r_s_cur  <= w_sig_src;
            r_s_prev <= r_s_cur;
            r_vld    <= {r_vld[VLD_W-2:0], 1'b1};
        end
    end

    // Edges are qualified by r_vld so a level already high at reset release
    // is not mistaken for a rising edge.
    assign w_rise = r_vld[VLD_W-1] & r_s_cur & ~r_s_prev;
    assign w_fall = r_vld[VLD_W-1] & ~r_s_cur & r_s_prev;

    // Saturation is reached on this edge and no new period has started.
    assign w_to = (r_cnt == CNT_PRE) & ~w_rise;

    // 3*high computed two bits wider so it cannot overflow.
    assign w_three_high = ({2'b00, r_high} << 1) + {2'b00, r_high};
    assign w_duty_hit   = (w_three_high == {2'b00, r_cnt});
    assign w_match      = r_have_prev & (r_high == high_cnt) & (r_cnt == period_cnt);

    // Cycle counter: restarts at 1 on each rise, otherwise counts up and holds at max.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= CNT_ONE;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Measurement state machine with registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_high      <= '0;
            r_have_prev <= 1'b0;
            meas_valid  <= 1'b0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            duty_33     <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_to) begin
                        r_state     <= ST_IDLE;
                        timeout     <= 1'b1;
                        locked      <= 1'b0;
                        r_have_prev <= 1'b0;
                    end else if (w_fall) begin
                        r_high  <= r_cnt;
                        r_state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        r_state     <= ST_HIGH;
                        period_cnt  <= r_cnt;
                        high_cnt    <= r_high;
                        meas_valid  <= 1'b1;
                        duty_33     <= w_duty_hit;
                        locked      <= w_match;
                        r_have_prev <= 1'b1;
                    end else if (w_to) begin
                        r_state     <= ST_IDLE;
                        timeout     <= 1'b1;
                        locked      <= 1'b0;
                        r_have_prev <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
